// File: rtl/ccp_msg1_queue_pkg.sv
// Shared definitions for the L1.5 -> L2 request channel: field widths and message type encodings.
// Every block on the channel imports these rather than redefining them.
package ccp_msg1_queue_pkg;

    localparam int MSG_WIDTH  = 3;
    localparam int DATA_WIDTH = 16;
    localparam int TAG_WIDTH  = 4;
    localparam int OWNER_BITS = 2;

    // MSG_NONE marks an empty slot on the wire; it is handshaken but never stored.
    typedef enum logic [MSG_WIDTH-1:0] {
        MSG_NONE        = 3'd0,
        MSG_LOAD_REQ    = 3'd1,
        MSG_STORE_REQ   = 3'd2,
        MSG_UPGRADE_REQ = 3'd3,
        MSG_WB_REQ      = 3'd4
    } ccp_msg_type_e;

    function automatic int entry_width(input int msg_w, input int data_w,
                                       input int tag_w, input int src_w);
        return msg_w + data_w + tag_w + src_w;
    endfunction

endpackage

// File: rtl/ccp_chan_storage.sv
// Message storage for a channel queue: one synchronous write port, one combinational read port.
// Contents are not reset; the owning queue tracks which entries are live.
module ccp_chan_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [W-1:0]             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [W-1:0]             o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ccp_msg1_queue.sv
// Channel-1 request FIFO between the L1.5 and the L2, with a sticky flag for producer
// handshake violations (message withdrawn or changed while stalled).
module ccp_msg1_queue
    import ccp_msg1_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int MSG_W  = MSG_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int TAG_W  = TAG_WIDTH,
    parameter int SRC_W  = OWNER_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MSG_W-1:0]           in_type,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [SRC_W-1:0]           in_source,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MSG_W-1:0]           out_type,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [SRC_W-1:0]           out_source,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = entry_width(MSG_W, DATA_W, TAG_W, SRC_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_proto_err;
    logic             r_prev_valid;
    logic             r_prev_ready;
    logic [ENT_W-1:0] r_prev_fields;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_violation;
    logic [ENT_W-1:0] w_in_fields;
    logic [ENT_W-1:0] w_head;

    // Valid/ready on both ports: a transfer happens on a rising edge where valid and ready are
    // both high; ready and valid depend only on registered count, never on the other side.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_in_fields = {in_type, in_data, in_tag, in_source};
    assign w_push      = in_valid && w_in_ready && (in_type != MSG_W'(MSG_NONE));
    assign w_pop       = w_out_valid && out_ready;

    // A stalled producer must hold its message unchanged until accepted.
    assign w_violation = r_prev_valid && !r_prev_ready &&
                         (!in_valid || (w_in_fields != r_prev_fields));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_valid  <= 1'b0;
            r_prev_ready  <= 1'b1;
            r_prev_fields <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_prev_valid  <= in_valid;
            r_prev_ready  <= w_in_ready;
            r_prev_fields <= w_in_fields;
            r_proto_err   <= r_proto_err | w_violation;
        end
    end

    ccp_chan_storage #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_storage (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_in_fields),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    assign {out_type, out_data, out_tag, out_source} = w_head;
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ccp_msg1_queue.sv
// Bench for ccp_msg1_queue: vector table for ordinary traffic, hand sequences for
// MSG_NONE, producer violations and asynchronous reset, plus an in-order scoreboard.
module tb_ccp_msg1_queue;

    localparam int W = 3 + 16 + 4 + 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [15:0] in_data;
    logic [3:0]  in_tag;
    logic [1:0]  in_source;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_type;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic [1:0]  out_source;
    logic [2:0]  count;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic       iv;
        logic [2:0] ty;
        logic [3:0] tag;
        logic [1:0] src;
        logic       ordy;
        logic [2:0] e_cnt;
        logic       e_ov;
        logic       e_ir;
        logic [3:0] e_tag;
        logic [1:0] e_src;
    } vec_t;

    vec_t vecs[$];

    ccp_msg1_queue #(
        .DEPTH  (4),
        .MSG_W  (3),
        .DATA_W (16),
        .TAG_W  (4),
        .SRC_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .in_source  (in_source),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_type   (out_type),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_source (out_source),
        .count      (count),
        .proto_err  (proto_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] tyof(input logic [3:0] tag);
        return 3'(tag % 4'd3) + 3'd1;
    endfunction

    function automatic logic [15:0] datof(input logic [3:0] tag);
        return {tag, ~tag, 8'hC3};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [3:0] tag, input logic [1:0] src,
                                input logic ordy, input logic [2:0] e_cnt, input logic e_ov,
                                input logic e_ir, input logic [3:0] e_tag, input logic [1:0] e_src);
        vec_t v;
        v.iv = iv; v.ty = iv ? tyof(tag) : 3'd0; v.tag = tag; v.src = src; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_tag = e_tag; v.e_src = e_src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [2:0] ty, input logic [3:0] tag,
                         input logic [1:0] src, input logic ordy);
        in_valid  = iv;
        in_type   = ty;
        in_tag    = tag;
        in_source = src;
        in_data   = datof(tag);
        out_ready = ordy;
    endtask

    task automatic push_msg(input logic [3:0] tag);
        drive(1'b1, tyof(tag), tag, tag[1:0], 1'b0);
        cyc();
    endtask

    // scoreboard: handshakes are sampled on the falling edge and take effect on the next rising edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_order", 32'({out_type, out_tag, out_source, out_data}),
                        32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready && in_type != 3'd0) begin
                exp_q.push_back({in_type, in_tag, in_source, in_data});
            end
        end
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 2'd0, 1'b0);

        // vector table
        vecs.push_back(mk(1, 3, 1, 0, 1, 1, 1, 3, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        for (int t = 1; t <= 4; t++)
            vecs.push_back(mk(1, 4'(t), 2'(t), 0, 3'(t), 1, (t != 4), 1, 1));
        vecs.push_back(mk(1, 5, 1, 0, 4, 1, 0, 1, 1));
        vecs.push_back(mk(1, 5, 1, 1, 3, 1, 1, 2, 2));
        vecs.push_back(mk(1, 5, 1, 1, 3, 1, 1, 3, 3));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1, 1, 4, 0));
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mk(1, 4'(5 + k), 2'(5 + k), 1, 2, 1, 1, 4'(4 + k), 2'(4 + k)));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 15, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));

        // reset state, then idle
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_proto_err", 32'(proto_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc();
        cyc();
        chk("idle_count", 32'(count), 0);
        chk("idle_out_valid", 32'(out_valid), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ty, vecs[i].tag, vecs[i].src, vecs[i].ordy);
            cyc();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_proto_err", i), 32'(proto_err), 0);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].e_tag));
                chk($sformatf("vec%0d_src", i), 32'(out_source), 32'(vecs[i].e_src));
                chk($sformatf("vec%0d_type", i), 32'(out_type), 32'(tyof(vecs[i].e_tag)));
                chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(datof(vecs[i].e_tag)));
            end
        end

        // MSG_NONE is handshaken but not stored
        drive(1'b1, 3'd0, 4'd6, 2'd2, 1'b0);
        #1;
        chk("none_in_ready", 32'(in_ready), 1);
        cyc();
        chk("none_empty_count", 32'(count), 0);
        chk("none_empty_out_valid", 32'(out_valid), 0);
        push_msg(4'd7);
        drive(1'b1, 3'd0, 4'd8, 2'd0, 1'b0);
        cyc();
        chk("none_count_kept", 32'(count), 1);
        chk("none_head_tag", 32'(out_tag), 7);
        drive(1'b0, 3'd0, 4'd0, 2'd0, 1'b1);
        cyc();
        chk("none_drain_count", 32'(count), 0);

        // MSG_NONE while full, then withdrawn
        for (int t = 1; t <= 4; t++) push_msg(4'(t));
        drive(1'b1, 3'd0, 4'd9, 2'd1, 1'b0);
        cyc();
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), 4);
        chk("stall_proto_err", 32'(proto_err), 0);
        drive(1'b0, 3'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        chk("withdraw_proto_err", 32'(proto_err), 1);
        chk("withdraw_count", 32'(count), 4);
        cyc();
        chk("sticky_proto_err", 32'(proto_err), 1);
        out_ready = 1'b1;
        cyc();
        chk("pop_to3_count", 32'(count), 3);
        chk("pop_to3_head", 32'(out_tag), 2);
        out_ready = 1'b0;

        // asynchronous reset mid-cycle with count 3
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_out_valid", 32'(out_valid), 0);
        chk("async_rst_in_ready", 32'(in_ready), 1);
        chk("async_rst_proto_err", 32'(proto_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("post_rst_count", 32'(count), 0);
        push_msg(4'd9);
        chk("post_rst_out_valid", 32'(out_valid), 1);
        chk("post_rst_tag", 32'(out_tag), 9);
        chk("post_rst_count1", 32'(count), 1);

        // stalled message changed before acceptance
        for (int t = 10; t <= 12; t++) push_msg(4'(t));
        drive(1'b1, tyof(4'd13), 4'd13, 2'd1, 1'b0);
        cyc();
        chk("change_stall_proto_err", 32'(proto_err), 0);
        chk("change_stall_in_ready", 32'(in_ready), 0);
        drive(1'b1, tyof(4'd14), 4'd14, 2'd1, 1'b0);
        cyc();
        chk("change_proto_err", 32'(proto_err), 1);
        chk("change_head_tag", 32'(out_tag), 9);
        drive(1'b0, 3'd0, 4'd0, 2'd0, 1'b0);
        cyc();
        chk("sb_depth", 32'(exp_q.size()), 32'(count));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
